// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states,
// well-known instruction encodings, default reset PC and a range helper.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

   localparam logic [15:0] NOP_INSTR          = 16'h0000;
   localparam logic [15:0] DEFAULT_HALT_INSTR = 16'hFFFF;
   localparam logic [15:0] DEFAULT_RESET_PC   = 16'h0000;

   // True when a word address lies beyond the populated instruction memory.
   function automatic logic pc_out_of_range(input logic [15:0] pc,
                                            input logic [31:0] mem_words);
      return ({16'h0000, pc} >= mem_words);
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer (master) and the core/memory side
// (slave): memory address/read port, hazard/branch controls, IF/ID outputs.
interface instr_fetch_ctrl_if;

   logic [15:0] A_InstrAddress;
   logic        C_IMRead;
   logic [15:0] D_Instruction;
   logic        C_Stall;
   logic        C_Redirect;
   logic [15:0] D_RedirectPC;
   logic [15:0] D_IR;
   logic [15:0] D_IRPC;
   logic        C_IRValid;
   logic        C_Halted;
   logic        C_Fault;

   modport master (
      output A_InstrAddress,
      output C_IMRead,
      input  D_Instruction,
      input  C_Stall,
      input  C_Redirect,
      input  D_RedirectPC,
      output D_IR,
      output D_IRPC,
      output C_IRValid,
      output C_Halted,
      output C_Fault
   );

   modport slave (
      input  A_InstrAddress,
      input  C_IMRead,
      output D_Instruction,
      output C_Stall,
      output C_Redirect,
      output D_RedirectPC,
      input  D_IR,
      input  D_IRPC,
      input  C_IRValid,
      input  C_Halted,
      input  C_Fault
   );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// read port and fills the IF/ID register. Redirects (branch/jump) beat
// stalls, and clear HALT/FAULT because those may lie on a squashed path.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          MEM_WORDS  = 8192,
   parameter logic [15:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
   input  logic                      clk,
   input  logic                      rst,
   instr_fetch_ctrl_if.master        bus
);

   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  ir_q, ir_d;
   logic [15:0]  irpc_q, irpc_d;
   logic         valid_q, valid_d;
   logic         halted_q, halted_d;
   logic         fault_q, fault_d;

   logic         pc_oob_s;
   logic         imread_s;

   // Range check of the current PC and the combinational memory read enable.
   always_comb begin
      pc_oob_s = pc_out_of_range(pc_q, MEM_WORDS_W);
      imread_s = (state_q == ST_FETCH) && !bus.C_Stall && !pc_oob_s;
   end

   // Next-state logic: priority is redirect, then stall, then normal work.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      irpc_d   = irpc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      fault_d  = fault_q;

      case (state_q)
         ST_IDLE: begin
            // Redirects are ignored until fetch has actually started.
            state_d = ST_FETCH;
         end

         ST_FETCH, ST_HALT, ST_FAULT: begin
            if (bus.C_Redirect) begin
               pc_d     = bus.D_RedirectPC;
               ir_d     = NOP_INSTR;
               valid_d  = 1'b0;
               halted_d = 1'b0;
               fault_d  = 1'b0;
               state_d  = ST_FETCH;
            end else if (bus.C_Stall) begin
               state_d = state_q;
            end else if (state_q == ST_FETCH) begin
               if (pc_oob_s) begin
                  // Nothing was read this cycle: insert a bubble and park.
                  ir_d    = NOP_INSTR;
                  valid_d = 1'b0;
                  fault_d = 1'b1;
                  state_d = ST_FAULT;
               end else begin
                  ir_d    = bus.D_Instruction;
                  irpc_d  = pc_q;
                  valid_d = 1'b1;
                  if (bus.D_Instruction == HALT_INSTR) begin
                     // PC stays on the HALT word so a debugger sees where it stopped.
                     halted_d = 1'b1;
                     state_d  = ST_HALT;
                  end else begin
                     pc_d = pc_q + 16'd1;
                  end
               end
            end else begin
               // HALT or FAULT: feed bubbles downstream.
               ir_d    = NOP_INSTR;
               valid_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, PC and IF/ID registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= NOP_INSTR;
         irpc_q   <= 16'h0000;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         irpc_q   <= irpc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.A_InstrAddress = pc_q;
   assign bus.C_IMRead       = imread_s;
   assign bus.D_IR           = ir_q;
   assign bus.D_IRPC         = irpc_q;
   assign bus.C_IRValid      = valid_q;
   assign bus.C_Halted       = halted_q;
   assign bus.C_Fault        = fault_q;

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch sequencer sitting between the core's hazard/branch logic and `instructionMemory`. Owns the program counter, drives the memory address and read enable, and latches each returned 16-bit word into the IF/ID register with its PC and a valid bit. Handles pipeline stalls, branch/jump redirects with flush, HALT detection, and out-of-range PC faults.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `MEM_WORDS`, 8192: number of valid instruction words; a PC at or above this value faults.
- `HALT_INSTR`, 16'hFFFF: encoding that stops fetch.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `A_InstrAddress` out 16: word address to `instructionMemory`; always equals the PC register.
- `C_IMRead` out 1: memory read enable.
- `D_Instruction` in 16: combinational read data from `instructionMemory`.
- `C_Stall` in 1: hazard unit hold request.
- `C_Redirect` in 1: branch/jump taken, one cycle pulse.
- `D_RedirectPC` in 16: redirect target, sampled when `C_Redirect`=1.
- `D_IR` out 16: IF/ID instruction.
- `D_IRPC` out 16: PC of `D_IR`.
- `C_IRValid` out 1: `D_IR` holds a real instruction.
- `C_Halted` out 1: the block is in HALT.
- `C_Fault` out 1: the block is in FAULT.

## Operation
- States: IDLE, FETCH, HALT, FAULT.
- Reset values:
  - PC = `RESET_PC`.
  - `C_IMRead` = 0.
  - `D_IR` = 16'h0000 (NOP).
  - `D_IRPC` = 0.
  - `C_IRValid` = 0.
  - `C_Halted` = 0, `C_Fault` = 0.
  - State = IDLE.
- IDLE:
  - `C_IMRead` = 0.
  - Moves to FETCH on the first edge after `rst` deasserts.
  - `C_Redirect` is ignored in IDLE.
- Per-edge priority: `rst` > `C_Redirect` > `C_Stall` > normal.
- FETCH, normal cycle:
  - Outputs: `C_IMRead` = 1.
  - At the edge: `D_IR` <= `D_Instruction`, `D_IRPC` <= PC, `C_IRValid` <= 1, PC <= PC+1 (16-bit, wraps).
- FETCH, stall:
  - `C_IMRead` = 0.
  - PC, `D_IR`, `D_IRPC` and `C_IRValid` hold.
- Redirect, in any state except IDLE, and even while stalled:
  - At the edge: PC <= `D_RedirectPC`, `D_IR` <= NOP, `C_IRValid` <= 0, state <= FETCH.
  - HALT and FAULT are cleared, because they may have been reached on a speculative path.
- HALT detect (FETCH, unstalled, `D_Instruction` == `HALT_INSTR`):
  - The HALT word is latched valid like any other instruction.
  - PC is not incremented; state <= HALT.
- HALT state:
  - `C_IMRead` = 0, `C_Halted` = 1.
  - Each unstalled edge loads a bubble: `D_IR` = NOP, `C_IRValid` = 0.
  - Stall holds the IF/ID register.
  - Exits only on reset or redirect.
- Fault (FETCH, PC >= `MEM_WORDS`):
  - Combinationally `C_IMRead` = 0.
  - At the unstalled edge: `C_IRValid` <= 0, state <= FAULT.
  - In FAULT: `C_Fault` = 1, `C_IMRead` = 0, bubbles as in HALT.
  - Exits on reset or redirect.
- A redirect to an out-of-range target enters FETCH, then faults on the following edge.
- Reset mid-operation clears everything asynchronously, including any in-flight redirect.

## Timing
- Address to IF/ID latency: 1 cycle. An address presented in cycle N appears in `D_IR` after edge N.
- Sustained throughput: 1 instruction per cycle without stalls.
- Redirect penalty:
  - Edge N: redirect sampled, bubble loaded.
  - Edge N+1: target instruction valid in `D_IR`.
- `C_IMRead` is combinational from state, `C_Stall` and the range check.
- All other outputs are registered.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE/FETCH/HALT/FAULT);
  - `NOP_INSTR` = 16'h0000;
  - default `HALT_INSTR`;
  - default `RESET_PC`.
- Single module, with no sub-module. The PC register, FSM and IF/ID register are too tightly coupled to split.

## Test plan
- Reset then run:
  - Stimulus: `rst` 1→0, memory[0..3] = 16'h1001, 16'h1002, 16'h1003, 16'h1004.
  - Response: `D_IR` = 1001/1002/1003 on edges 2, 3 and 4 after reset release, `D_IRPC` = 0/1/2, `C_IRValid` = 1.
- Stall:
  - Stimulus: `C_Stall` = 1 for 3 cycles while `D_IR` = 16'h1002.
  - Response: `D_IR`, `D_IRPC` = 1 and PC = 2 hold; `C_IMRead` = 0; fetch resumes with 16'h1003.
- Redirect during stall:
  - Stimulus: `C_Stall` = 1 and `C_Redirect` = 1 with target 16'h0040.
  - Response: next edge `C_IRValid` = 0, `D_IR` = 0; the following edge `D_IRPC` = 16'h0040.
- HALT:
  - Stimulus: memory[5] = 16'hFFFF.
  - Response: `D_IR` = FFFF valid for one cycle, then `C_Halted` = 1, `C_IRValid` = 0, PC stays 5.
  - Follow-up: a redirect to 16'h0000 resumes fetch with `C_Halted` = 0.
- Fault:
  - Stimulus: redirect to 16'h2000 with `MEM_WORDS` = 8192.
  - Response: one FETCH cycle with `C_IMRead` = 0, then `C_Fault` = 1 and no valid instructions.
- Async reset mid-run: `rst` pulsed between edges → all outputs take their reset values immediately, without waiting for an edge.
